// File: rtl/dsp_accumulator.sv
// Block accumulator: sums LEN signed products with saturating arithmetic and
// hands the total downstream over a valid/ready handshake.
module dsp_accumulator #(
  parameter int DATA_WIDTH  = 32,
  parameter int ACC_WIDTH   = 48,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   ap_ready,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  input  logic                   acc_ready,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, DONE} state_t;

  localparam logic [ACC_WIDTH-1:0]   ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]   ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic [COUNT_WIDTH-1:0] len_reg, len_next;
  logic                   overflow_reg, overflow_next;

  // One guard bit: a signed overflow shows up as the top two sum bits disagreeing.
  logic [ACC_WIDTH:0]     sum_wide;
  logic                   sum_ovf;
  logic [COUNT_WIDTH-1:0] count_inc;

  assign sum_wide  = {acc_reg[ACC_WIDTH-1], acc_reg}
                   + {{(ACC_WIDTH+1-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign sum_ovf   = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
  assign count_inc = count_reg + COUNT_ONE;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      count_reg    <= '0;
      len_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    len_next      = len_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      IDLE: begin
        if (ap_start) begin
          len_next      = len;
          acc_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
          state_next    = (len == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (sum_ovf) begin
            // Sign of the wide sum tells which rail was crossed.
            acc_next      = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            overflow_next = 1'b1;
          end else begin
            acc_next = sum_wide[ACC_WIDTH-1:0];
          end
          count_next = count_inc;
          if (count_inc == len_reg) begin
            state_next = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (acc_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ap_idle   = (state_reg == IDLE);
  assign ap_ready  = (state_reg == IDLE);
  assign acc_valid = (state_reg == OUTPUT);
  assign ap_done   = (state_reg == DONE);
  assign acc_out   = acc_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_dsp_accumulator.sv
// Directed bench for dsp_accumulator: expected block sums are queued as samples
// are driven and popped when the accumulator presents its result.
module tb_dsp_accumulator;

  localparam int DW = 32;
  localparam int AW = 40;
  localparam int CW = 16;
  localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (AW-1));

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_ready;
  logic [CW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          overflow;

  int checks = 0;
  int fails  = 0;

  longint      exp_acc;
  logic        exp_ovf;
  logic [AW:0] sb[$];

  dsp_accumulator #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .COUNT_WIDTH(CW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .acc_out  (acc_out),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .overflow (overflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact integer sum, clamped to the accumulator range.
  task automatic model_add(input longint d);
    exp_acc = exp_acc + d;
    if (exp_acc > MAXV) begin
      exp_acc = MAXV;
      exp_ovf = 1'b1;
    end else if (exp_acc < MINV) begin
      exp_acc = MINV;
      exp_ovf = 1'b1;
    end
  endtask

  task automatic push_expected();
    logic [AW:0] e;
    e = {exp_ovf, exp_acc[AW-1:0]};
    sb.push_back(e);
  endtask

  task automatic start_block(input int n);
    ap_start = 1'b1;
    len      = CW'(n);
    step();
    ap_start = 1'b0;
    exp_acc  = 0;
    exp_ovf  = 1'b0;
    check("start_not_idle", ap_idle, 0);
    check("start_ovf_cleared", overflow, 0);
    check("start_acc_cleared", acc_out, 0);
    if (n == 0) push_expected();
  endtask

  task automatic send(input longint d);
    check("no_early_valid", acc_valid, 0);
    in_valid = 1'b1;
    in_data  = d[DW-1:0];
    step();
    in_valid = 1'b0;
    in_data  = '0;
    model_add(d);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      check("no_valid_in_gap", acc_valid, 0);
      step();
    end
  endtask

  // Result must already be valid; optionally stall the handshake and poke ap_start.
  task automatic finish_block(input int hold, input logic poke_start);
    logic [AW:0]   e;
    logic [AW-1:0] held;
    check("valid_latency", acc_valid, 1);
    check("sb_nonempty", sb.size() != 0, 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check("acc_out", acc_out, e[AW-1:0]);
    check("overflow", overflow, e[AW]);
    held = acc_out;
    for (int i = 0; i < hold; i++) begin
      acc_ready = 1'b0;
      ap_start  = poke_start;
      len       = 16'd7;
      step();
      ap_start  = 1'b0;
      check("hold_valid", acc_valid, 1);
      check("hold_acc_stable", acc_out, held);
      check("hold_no_done", ap_done, 0);
    end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    check("done_pulse", ap_done, 1);
    check("done_valid_low", acc_valid, 0);
    check("done_acc_kept", acc_out, held);
    step();
    check("done_one_cycle", ap_done, 0);
    check("back_idle", ap_idle, 1);
    check("back_ready", ap_ready, 1);
  endtask

  initial begin
    ap_rst    = 1'b1;
    ap_start  = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_ready = 1'b0;
    step();
    step();
    ap_rst = 1'b0;
    check("rst_idle", ap_idle, 1);
    check("rst_ready", ap_ready, 1);
    check("rst_valid", acc_valid, 0);
    check("rst_done", ap_done, 0);
    check("rst_acc", acc_out, 0);
    check("rst_ovf", overflow, 0);

    // Back-to-back samples with acc_ready held high throughout.
    acc_ready = 1'b1;
    start_block(4);
    send(3); send(-5); send(10); send(7);
    push_expected();
    $display("block len=4 3,-5,10,7 expected 15");
    finish_block(0, 1'b0);

    // Stalled input stream.
    start_block(3);
    send(1); gap(2); send(2); gap(2); send(3);
    push_expected();
    $display("block len=3 with stalls expected 6");
    finish_block(0, 1'b0);

    // Back-pressure on the result with ap_start poked while waiting.
    start_block(2);
    send(100); send(-40);
    push_expected();
    $display("block len=2 with 5-cycle back-pressure expected 60");
    finish_block(5, 1'b1);

    // Empty block.
    start_block(0);
    $display("block len=0 expected 0");
    finish_block(0, 1'b0);

    // Positive saturation.
    start_block(300);
    for (int i = 0; i < 300; i++) send(64'sh7FFFFFFF);
    push_expected();
    $display("block len=300 of 0x7FFFFFFF expected saturated max");
    finish_block(0, 1'b0);

    // Samples outside ACCUM are ignored; overflow clears on the next start.
    in_valid = 1'b1;
    in_data  = 32'd1000;
    step();
    step();
    in_valid = 1'b0;
    check("idle_ignores_input", ap_idle, 1);
    start_block(1);
    send(5);
    push_expected();
    $display("block len=1 sample 5 after saturation expected 5");
    finish_block(0, 1'b0);

    // Negative saturation, then continue from the clamped value.
    start_block(301);
    for (int i = 0; i < 300; i++) send(-64'sd2147483648);
    send(1000);
    push_expected();
    $display("block len=301 min then +1000 expected min+1000 with overflow");
    finish_block(0, 1'b0);

    // Reset mid-block abandons it without a done pulse.
    start_block(4);
    send(11); send(22);
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    check("midrst_idle", ap_idle, 1);
    check("midrst_valid", acc_valid, 0);
    check("midrst_acc", acc_out, 0);
    check("midrst_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_done", ap_done, 0);
      step();
    end
    start_block(1);
    send(9);
    push_expected();
    $display("block len=1 sample 9 after reset expected 9");
    finish_block(0, 1'b0);

    check("sb_drained", sb.size() == 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
